// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
//   Registered ALU/FPU control decoder and multi-cycle op sequencer for
//   IITK-Mini-MIPS. It sits between ID and EX. It decodes alu_op, funct and
//   fp_operation into a CTRL_W-bit control code. It holds that code for the
//   latency of MUL, MADD/MADDU and ADD.S/SUB.S, and stalls ID through in_ready
//   while the op is running.
//
//   Optional build macro: ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
//     When defined, an undecodable funct raises a one-cycle 'illegal' pulse
//     and loads alu_ctrl with all-ones. The op is not issued.
//     When undefined, the funct decodes to code 00 as a single-cycle op, and
//     'illegal' is tied low.
//
//   Ports
//     clk, rst_n    clock; synchronous active-low reset
//     in_valid      decoded instruction fields are present
//     in_ready      block can accept a new op (rst_n && cnt==0)
//     alu_op        00 ADD, 01 SUB, 10 R-type funct, 11 I-type logical
//     funct         R-type/FP function field
//     fp_operation  FP instruction; overrides alu_op
//     flush         kill the in-flight op, or the op being accepted this cycle
//     ctrl_valid    alu_ctrl is valid for EX
//     alu_ctrl      registered control code
//     op_done       final cycle of the current op
//     hilo_we       HI/LO write strobe on the final cycle of MUL/MADD/MADDU
//     fp_neg_b      negate FPU operand B (SUB.S)
//     illegal       undecodable-funct pulse (trap build only)
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
    parameter int unsigned CTRL_W  = 5,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned FP_LAT  = 2,
    parameter int unsigned CNT_W   = $clog2(MUL_LAT + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              fp_operation,
    input  logic              flush,
    output logic              ctrl_valid,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              op_done,
    output logic              hilo_we,
    output logic              fp_neg_b,
    output logic              illegal
);

    typedef enum logic [4:0] {
        C_AND   = 5'h00, C_OR    = 5'h01, C_ADD   = 5'h02, C_ADDU  = 5'h03,
        C_SUB   = 5'h04, C_SUBU  = 5'h05, C_XOR   = 5'h06, C_NOR   = 5'h07,
        C_SLL   = 5'h08, C_SRL   = 5'h09, C_SRA   = 5'h0A, C_MUL   = 5'h0B,
        C_MADD  = 5'h0C, C_MADDU = 5'h0D, C_SLT   = 5'h0E, C_SLTU  = 5'h0F,
        C_FADD  = 5'h10, C_FSUB  = 5'h11, C_FMOV  = 5'h12, C_FCEQ  = 5'h13,
        C_FCLT  = 5'h14
    } code_e;

    // Counter start value is latency-1; a single-cycle op starts at zero.
    localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MADD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_FP   = CNT_W'(FP_LAT - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_ctrl_valid;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic              r_fp_neg_b;

    code_e             w_code;
    logic [CNT_W-1:0]  w_cnt_init;
    logic              w_neg_b;
    logic              w_accept;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
    logic              w_undef;
    logic              r_illegal;
`endif

    always_comb begin
        w_code     = C_AND;
        w_cnt_init = '0;
        w_neg_b    = 1'b0;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
        w_undef    = 1'b0;
`endif
        if (fp_operation) begin
            case (funct)
                6'b000000: begin w_code = C_FADD; w_cnt_init = CNT_FP; end
                6'b000001: begin w_code = C_FSUB; w_cnt_init = CNT_FP; w_neg_b = 1'b1; end
                6'b000010: w_code = C_FMOV;
                6'b000100: w_code = C_FCEQ;
                6'b000110: w_code = C_FCLT;
                default: begin
                    w_code = C_AND;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
                    w_undef = 1'b1;
`endif
                end
            endcase
        end else begin
            case (alu_op)
                2'b00: w_code = C_ADD;
                2'b01: w_code = C_SUB;
                2'b10: begin
                    case (funct)
                        6'b100100: w_code = C_AND;
                        6'b100101: w_code = C_OR;
                        6'b100000: w_code = C_ADD;
                        6'b100001: w_code = C_ADDU;
                        6'b100010: w_code = C_SUB;
                        6'b100011: w_code = C_SUBU;
                        6'b100110: w_code = C_XOR;
                        6'b100111: w_code = C_NOR;
                        6'b000000: w_code = C_SLL;
                        6'b000010: w_code = C_SRL;
                        6'b000011: w_code = C_SRA;
                        6'b011000: begin w_code = C_MUL;   w_cnt_init = CNT_MUL;  end
                        6'b000100: begin w_code = C_MADD;  w_cnt_init = CNT_MADD; end
                        6'b000101: begin w_code = C_MADDU; w_cnt_init = CNT_MADD; end
                        6'b101010: w_code = C_SLT;
                        6'b101011: w_code = C_SLTU;
                        default: begin
                            w_code = C_AND;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
                            w_undef = 1'b1;
`endif
                        end
                    endcase
                end
                2'b11: begin
                    case (funct[5:3])
                        3'b100:  w_code = C_AND;
                        3'b101:  w_code = C_OR;
                        3'b110:  w_code = C_XOR;
                        default: w_code = C_ADD;
                    endcase
                end
            endcase
        end
    end

    assign in_ready = rst_n && (r_cnt == '0);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl_valid <= 1'b0;
            r_alu_ctrl   <= '0;
            r_cnt        <= '0;
            r_fp_neg_b   <= 1'b0;
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
            r_illegal    <= 1'b0;
`endif
        end else begin
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
            // flush wins over both the countdown and a same-cycle accept
            if (flush) begin
                r_ctrl_valid <= 1'b0;
                r_cnt        <= '0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (w_accept) begin
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
                if (w_undef) begin
                    r_illegal    <= 1'b1;
                    r_ctrl_valid <= 1'b0;
                    r_alu_ctrl   <= CTRL_W'(5'h1F);
                    r_cnt        <= '0;
                end else
`endif
                begin
                    r_ctrl_valid <= 1'b1;
                    r_alu_ctrl   <= CTRL_W'(w_code);
                    r_fp_neg_b   <= w_neg_b;
                    r_cnt        <= w_cnt_init;
                end
            end else begin
                r_ctrl_valid <= 1'b0;
            end
        end
    end

    assign ctrl_valid = r_ctrl_valid;
    assign alu_ctrl   = r_alu_ctrl;
    assign fp_neg_b   = r_fp_neg_b;
    assign op_done    = r_ctrl_valid && (r_cnt == '0);
    assign hilo_we    = op_done && ((r_alu_ctrl == CTRL_W'(C_MUL))  ||
                                    (r_alu_ctrl == CTRL_W'(C_MADD)) ||
                                    (r_alu_ctrl == CTRL_W'(C_MADDU)));
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
    assign illegal    = r_illegal;
`else
    assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
//   Directed bench for alu_ctrl_seq with default parameters
//   (CTRL_W=5, MUL_LAT=3, FP_LAT=2). An accepted op pushes its expected
//   code, fp_neg_b and hilo_we onto a queue. A negedge monitor pops the queue
//   on every op_done and compares. The linear sequence checks cycle-level
//   timing of ctrl_valid, in_ready, op_done and illegal.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;

    localparam int unsigned CTRL_W = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              fp_operation;
    logic              flush;
    logic              ctrl_valid;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              op_done;
    logic              hilo_we;
    logic              fp_neg_b;
    logic              illegal;

    alu_ctrl_seq #(
        .CTRL_W  (CTRL_W),
        .MUL_LAT (3),
        .FP_LAT  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .funct        (funct),
        .fp_operation (fp_operation),
        .flush        (flush),
        .ctrl_valid   (ctrl_valid),
        .alu_ctrl     (alu_ctrl),
        .op_done      (op_done),
        .hilo_we      (hilo_we),
        .fp_neg_b     (fp_neg_b),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CTRL_W-1:0] code;
        logic              neg;
        logic              hilo;
    } exp_t;

    typedef struct packed {
        logic [1:0] op;
        logic [5:0] f;
        logic       fp;
        logic [4:0] code;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    // single-cycle decodes streamed back to back
    vec_t tbl [14] = '{
        '{2'b00, 6'h06, 1'b1, 5'h14},   // C.LT.S
        '{2'b10, 6'h02, 1'b1, 5'h12},   // MOV.S (fp overrides alu_op)
        '{2'b11, 6'h04, 1'b1, 5'h13},   // C.EQ.S
        '{2'b11, 6'h28, 1'b0, 5'h01},   // I-type 101xxx
        '{2'b11, 6'h27, 1'b0, 5'h00},   // I-type 100xxx
        '{2'b11, 6'h32, 1'b0, 5'h06},   // I-type 110xxx
        '{2'b11, 6'h03, 1'b0, 5'h02},   // I-type other
        '{2'b00, 6'h2A, 1'b0, 5'h02},   // lw/sw/addi
        '{2'b01, 6'h20, 1'b0, 5'h04},   // beq/bne
        '{2'b10, 6'h24, 1'b0, 5'h00},   // AND
        '{2'b10, 6'h03, 1'b0, 5'h0A},   // SRA
        '{2'b10, 6'h2B, 1'b0, 5'h0F},   // SLTU
        '{2'b10, 6'h27, 1'b0, 5'h07},   // NOR
        '{2'b10, 6'h00, 1'b0, 5'h08}    // SLL
    };

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [CTRL_W-1:0] obs,
                        input logic [CTRL_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic fp);
        in_valid     = 1'b1;
        alu_op       = op;
        funct        = f;
        fp_operation = fp;
    endtask

    task automatic offer(input logic [1:0] op, input logic [5:0] f, input logic fp,
                         input logic [4:0] code, input logic neg, input logic hw);
        exp_t e;
        drive(op, f, fp);
        e.code = CTRL_W'(code);
        e.neg  = neg;
        e.hilo = hw;
        sb.push_back(e);
    endtask

    task automatic idle;
        in_valid = 1'b0;
    endtask

    // completion monitor
    always @(negedge clk) begin
        if (op_done === 1'b1) begin
            chk1("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chkc("done_ctrl", alu_ctrl, mon_e.code);
                chk1("done_neg", fp_neg_b, mon_e.neg);
                chk1("done_hilo", hilo_we, mon_e.hilo);
            end
        end else begin
            chk1("hilo_without_done", hilo_we, 1'b0);
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'b00; funct = 6'h00;
        fp_operation = 1'b0; flush = 1'b0;

        // reset
        tick; tick;
        chk1("rst_valid", ctrl_valid, 1'b0);
        chkc("rst_ctrl", alu_ctrl, 5'h00);
        chk1("rst_ready", in_ready, 1'b0);
        chk1("rst_done", op_done, 1'b0);
        chk1("rst_neg", fp_neg_b, 1'b0);
        chk1("rst_illegal", illegal, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("ready_after_rst", in_ready, 1'b1);

        // ADD then SLT streaming
        offer(2'b10, 6'h20, 1'b0, 5'h02, 1'b0, 1'b0);
        tick;
        offer(2'b10, 6'h2A, 1'b0, 5'h0E, 1'b0, 1'b0);
        chkc("add_ctrl", alu_ctrl, 5'h02);
        chk1("add_valid", ctrl_valid, 1'b1);
        chk1("add_done", op_done, 1'b1);
        chk1("add_ready", in_ready, 1'b1);
        tick; idle();
        chkc("slt_ctrl", alu_ctrl, 5'h0E);
        chk1("slt_valid", ctrl_valid, 1'b1);
        chk1("slt_done", op_done, 1'b1);
        chk1("slt_ready", in_ready, 1'b1);
        tick;
        chk1("gap_valid", ctrl_valid, 1'b0);
        chkc("gap_hold", alu_ctrl, 5'h0E);
        chk1("gap_done", op_done, 1'b0);

        // MUL, 3 cycles
        offer(2'b10, 6'h18, 1'b0, 5'h0B, 1'b0, 1'b1);
        tick; idle();
        chkc("mul1_ctrl", alu_ctrl, 5'h0B);
        chk1("mul1_valid", ctrl_valid, 1'b1);
        chk1("mul1_ready", in_ready, 1'b0);
        chk1("mul1_done", op_done, 1'b0);
        tick;
        chk1("mul2_valid", ctrl_valid, 1'b1);
        chk1("mul2_ready", in_ready, 1'b0);
        chk1("mul2_done", op_done, 1'b0);
        tick;
        chk1("mul3_valid", ctrl_valid, 1'b1);
        chk1("mul3_done", op_done, 1'b1);
        chk1("mul3_hilo", hilo_we, 1'b1);
        chk1("mul3_ready", in_ready, 1'b1);
        tick;
        chk1("mul_after_valid", ctrl_valid, 1'b0);

        // MADD, ADD.S held during the stall and accepted on the op_done cycle
        offer(2'b10, 6'h04, 1'b0, 5'h0C, 1'b0, 1'b1);
        tick;
        offer(2'b00, 6'h00, 1'b1, 5'h10, 1'b0, 1'b0);
        chkc("madd1_ctrl", alu_ctrl, 5'h0C);
        chk1("madd1_ready", in_ready, 1'b0);
        tick;
        chkc("madd2_ctrl", alu_ctrl, 5'h0C);
        chk1("madd2_ready", in_ready, 1'b0);
        chk1("madd2_done", op_done, 1'b0);
        tick;
        chk1("madd3_ready", in_ready, 1'b0);
        chk1("madd3_done", op_done, 1'b0);
        tick;
        chkc("madd4_ctrl", alu_ctrl, 5'h0C);
        chk1("madd4_done", op_done, 1'b1);
        chk1("madd4_hilo", hilo_we, 1'b1);
        chk1("madd4_ready", in_ready, 1'b1);
        tick; idle();
        chkc("fadd1_ctrl", alu_ctrl, 5'h10);
        chk1("fadd1_valid", ctrl_valid, 1'b1);
        chk1("fadd1_done", op_done, 1'b0);
        chk1("fadd1_ready", in_ready, 1'b0);
        tick;
        chkc("fadd2_ctrl", alu_ctrl, 5'h10);
        chk1("fadd2_done", op_done, 1'b1);
        tick;
        chk1("fadd_after_valid", ctrl_valid, 1'b0);

        // SUB.S
        offer(2'b00, 6'h01, 1'b1, 5'h11, 1'b1, 1'b0);
        tick; idle();
        chkc("subs1_ctrl", alu_ctrl, 5'h11);
        chk1("subs1_neg", fp_neg_b, 1'b1);
        chk1("subs1_ready", in_ready, 1'b0);
        tick;
        chk1("subs2_done", op_done, 1'b1);
        chk1("subs2_neg", fp_neg_b, 1'b1);

        // single-cycle decode table, streamed
        for (int i = 0; i < 14; i++) begin
            offer(tbl[i].op, tbl[i].f, tbl[i].fp, tbl[i].code, 1'b0, 1'b0);
            tick;
            chkc($sformatf("tbl%0d_ctrl", i), alu_ctrl, CTRL_W'(tbl[i].code));
            chk1($sformatf("tbl%0d_done", i), op_done, 1'b1);
            chk1($sformatf("tbl%0d_neg", i), fp_neg_b, 1'b0);
            chk1($sformatf("tbl%0d_ready", i), in_ready, 1'b1);
        end
        idle();
        tick;

        // flush on cycle 2 of MUL
        offer(2'b10, 6'h18, 1'b0, 5'h0B, 1'b0, 1'b1);
        tick; idle();
        chk1("fl_mul1_valid", ctrl_valid, 1'b1);
        tick;
        flush = 1'b1;
        void'(sb.pop_back());
        chk1("fl_ready_unaffected", in_ready, 1'b0);
        tick;
        flush = 1'b0;
        chk1("fl_valid", ctrl_valid, 1'b0);
        chk1("fl_done", op_done, 1'b0);
        chk1("fl_hilo", hilo_we, 1'b0);
        chk1("fl_ready", in_ready, 1'b1);
        tick;
        chk1("fl_valid2", ctrl_valid, 1'b0);
        chk1("fl_done2", op_done, 1'b0);

        // flush together with an accept: op dropped
        drive(2'b10, 6'h20, 1'b0);
        flush = 1'b1;
        chk1("fa_ready", in_ready, 1'b1);
        tick; idle();
        flush = 1'b0;
        chk1("fa_valid", ctrl_valid, 1'b0);
        chk1("fa_done", op_done, 1'b0);
        chkc("fa_ctrl_hold", alu_ctrl, 5'h0B);
        tick;

        // undecodable funct
`ifdef ALU_CTRL_SEQ_ILLEGAL_TRAP_EN
        drive(2'b10, 6'h3F, 1'b0);
        tick; idle();
        chk1("ill_pulse", illegal, 1'b1);
        chkc("ill_ctrl", alu_ctrl, CTRL_W'(5'h1F));
        chk1("ill_valid", ctrl_valid, 1'b0);
        chk1("ill_done", op_done, 1'b0);
        chk1("ill_ready", in_ready, 1'b1);
        tick;
        chk1("ill_clear", illegal, 1'b0);
        chk1("ill_valid2", ctrl_valid, 1'b0);
`else
        offer(2'b10, 6'h3F, 1'b0, 5'h00, 1'b0, 1'b0);
        tick; idle();
        chkc("ill_ctrl", alu_ctrl, 5'h00);
        chk1("ill_valid", ctrl_valid, 1'b1);
        chk1("ill_done", op_done, 1'b1);
        chk1("ill_pulse", illegal, 1'b0);
        tick;
        chk1("ill_clear", illegal, 1'b0);
`endif

        // reset in the middle of MADD
        offer(2'b10, 6'h05, 1'b0, 5'h0D, 1'b0, 1'b1);
        tick; idle();
        chkc("rm_ctrl", alu_ctrl, 5'h0D);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk1("rm_ready_low", in_ready, 1'b0);
        tick;
        chk1("rm_valid", ctrl_valid, 1'b0);
        chkc("rm_ctrl_clr", alu_ctrl, 5'h00);
        chk1("rm_done", op_done, 1'b0);
        rst_n = 1'b1;
        tick;
        chk1("rm_done2", op_done, 1'b0);
        chk1("rm_ready", in_ready, 1'b1);
        tick;

        chk1("sb_empty", sb.size() == 0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
